id_ex_operand_stage: RTL and testbench

Pipeline register and operand-selection stage sitting directly upstream of the 16-bit execute ALU. It captures decoded instructions from the decode stage and applies EX/MEM and MEM/WB forwarding, so the ALU sees final operand values (`alu_a`, `alu_b`) and control fields (`alu_op`, `alu_inva`, `alu_invb`, `alu_cin`, `alu_sign`) every cycle. It also detects load-use hazards and inserts bubbles. It honours downstream stall and branch flush requests.

---
 rtl/id_ex_operand_stage.sv | 170 +++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_operand_stage
//  Purpose  : ID/EX pipeline register with EX/MEM and MEM/WB operand bypass,
//             load-use bubble insertion, stall hold and deferred flush.
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_operand_stage (
    input  logic        clk,
    input  logic        rst,

    input  logic        id_valid,
    input  logic [15:0] id_rs_data,
    input  logic [15:0] id_rt_data,
    input  logic [15:0] id_imm,
    input  logic        id_use_imm,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [2:0]  id_op,
    input  logic        id_inva,
    input  logic        id_invb,
    input  logic        id_cin,
    input  logic        id_sign,
    input  logic        id_wr_en,
    input  logic [2:0]  id_wr_reg,
    input  logic        id_is_load,

    input  logic        stall,
    input  logic        flush,

    input  logic        mem_fwd_en,
    input  logic [2:0]  mem_fwd_reg,
    input  logic [15:0] mem_fwd_data,
    input  logic        wb_fwd_en,
    input  logic [2:0]  wb_fwd_reg,
    input  logic [15:0] wb_fwd_data,

    output logic        hazard,
    output logic        ex_valid,
    output logic        ex_wr_en,
    output logic        ex_is_load,
    output logic [2:0]  ex_wr_reg,
    output logic [15:0] ex_st_data,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_inva,
    output logic        alu_invb,
    output logic        alu_cin,
    output logic        alu_sign
);

    typedef struct packed {
        logic        valid;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic        uses_rs;
        logic        uses_rt;
        logic [15:0] imm;
        logic        use_imm;
        logic [2:0]  op;
        logic        inva;
        logic        invb;
        logic        cin;
        logic        sign;
        logic        wr_en;
        logic [2:0]  wr_reg;
        logic        is_load;
    } stage_t;

    localparam stage_t c_bubble = '0;

    stage_t      r_stage;
    logic        r_flush_pend;
    stage_t      w_decode;
    logic        w_hazard;
    logic        w_kill;
    logic [15:0] w_fwd_rs;
    logic [15:0] w_fwd_rt;

    always_comb begin
        w_decode         = c_bubble;
        w_decode.valid   = id_valid;
        w_decode.rs_data = id_rs_data;
        w_decode.rt_data = id_rt_data;
        w_decode.rs      = id_rs;
        w_decode.rt      = id_rt;
        w_decode.uses_rs = id_uses_rs;
        w_decode.uses_rt = id_uses_rt;
        w_decode.imm     = id_imm;
        w_decode.use_imm = id_use_imm;
        w_decode.op      = id_op;
        w_decode.inva    = id_inva;
        w_decode.invb    = id_invb;
        w_decode.cin     = id_cin;
        w_decode.sign    = id_sign;
        w_decode.wr_en   = id_wr_en;
        w_decode.wr_reg  = id_wr_reg;
        w_decode.is_load = id_is_load;
    end

    // A load in EX cannot bypass its data until MEM/WB, so a consumer in decode waits one cycle.
    always_comb begin
        w_hazard = r_stage.valid & r_stage.is_load & r_stage.wr_en & id_valid &
                   ((id_uses_rs & (id_rs == r_stage.wr_reg)) |
                    (id_uses_rt & (id_rt == r_stage.wr_reg)));
    end

    assign w_kill = flush | r_flush_pend | w_hazard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stage      <= c_bubble;
            r_flush_pend <= 1'b0;
        end else if (stall) begin
            // A flush seen while frozen is remembered and applied once the stall lifts.
            if (flush) begin
                r_flush_pend <= 1'b1;
            end
        end else if (w_kill) begin
            r_stage      <= c_bubble;
            r_flush_pend <= 1'b0;
        end else begin
            r_stage      <= w_decode;
        end
    end

    // EX/MEM is newer than MEM/WB, so it wins when both target the same register.
    always_comb begin
        w_fwd_rs = r_stage.rs_data;
        if (r_stage.uses_rs) begin
            if (mem_fwd_en && (mem_fwd_reg == r_stage.rs)) begin
                w_fwd_rs = mem_fwd_data;
            end else if (wb_fwd_en && (wb_fwd_reg == r_stage.rs)) begin
                w_fwd_rs = wb_fwd_data;
            end
        end
    end

    always_comb begin
        w_fwd_rt = r_stage.rt_data;
        if (r_stage.uses_rt) begin
            if (mem_fwd_en && (mem_fwd_reg == r_stage.rt)) begin
                w_fwd_rt = mem_fwd_data;
            end else if (wb_fwd_en && (wb_fwd_reg == r_stage.rt)) begin
                w_fwd_rt = wb_fwd_data;
            end
        end
    end

    assign hazard     = w_hazard;
    assign ex_valid   = r_stage.valid;
    assign ex_wr_en   = r_stage.wr_en;
    assign ex_is_load = r_stage.is_load;
    assign ex_wr_reg  = r_stage.wr_reg;
    assign ex_st_data = w_fwd_rt;
    assign alu_a      = w_fwd_rs;
    assign alu_b      = r_stage.use_imm ? r_stage.imm : w_fwd_rt;
    assign alu_op     = r_stage.op;
    assign alu_inva   = r_stage.inva;
    assign alu_invb   = r_stage.invb;
    assign alu_cin    = r_stage.cin;
    assign alu_sign   = r_stage.sign;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_operand_stage
//  Purpose  : Scoreboard bench: directed scenarios plus random traffic checked
//             against an instruction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_operand_stage;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [15:0] imm;
        logic        use_imm;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic        uses_rs;
        logic        uses_rt;
        logic [2:0]  op;
        logic        inva;
        logic        invb;
        logic        cin;
        logic        sign;
        logic        wr_en;
        logic [2:0]  wr_reg;
        logic        is_load;
        logic        stall;
        logic        flush;
        logic        mem_en;
        logic [2:0]  mem_reg;
        logic [15:0] mem_data;
        logic        wb_en;
        logic [2:0]  wb_reg;
        logic [15:0] wb_data;
    } stim_t;

    typedef struct packed {
        logic        hazard;
        logic        ex_valid;
        logic        ex_wr_en;
        logic        ex_is_load;
        logic [2:0]  ex_wr_reg;
        logic [15:0] ex_st_data;
        logic [15:0] alu_a;
        logic [15:0] alu_b;
        logic [2:0]  alu_op;
        logic        alu_inva;
        logic        alu_invb;
        logic        alu_cin;
        logic        alu_sign;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid, id_use_imm, id_uses_rs, id_uses_rt;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic [2:0]  id_rs, id_rt, id_op, id_wr_reg;
    logic        id_inva, id_invb, id_cin, id_sign, id_wr_en, id_is_load;
    logic        stall, flush;
    logic        mem_fwd_en, wb_fwd_en;
    logic [2:0]  mem_fwd_reg, wb_fwd_reg;
    logic [15:0] mem_fwd_data, wb_fwd_data;
    logic        hazard, ex_valid, ex_wr_en, ex_is_load;
    logic [2:0]  ex_wr_reg, alu_op;
    logic [15:0] ex_st_data, alu_a, alu_b;
    logic        alu_inva, alu_invb, alu_cin, alu_sign;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t sb_q[$];

    // Reference state: the instruction currently in EX (a zero record is a bubble).
    stim_t m_ins;
    logic  m_pend;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_op(id_op),
        .id_inva(id_inva), .id_invb(id_invb), .id_cin(id_cin), .id_sign(id_sign),
        .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
        .stall(stall), .flush(flush),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_reg(mem_fwd_reg), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_reg(wb_fwd_reg), .wb_fwd_data(wb_fwd_data),
        .hazard(hazard), .ex_valid(ex_valid), .ex_wr_en(ex_wr_en),
        .ex_is_load(ex_is_load), .ex_wr_reg(ex_wr_reg), .ex_st_data(ex_st_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_inva(alu_inva),
        .alu_invb(alu_invb), .alu_cin(alu_cin), .alu_sign(alu_sign)
    );

    function automatic stim_t idle();
        stim_t s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    // Value the ALU sees for a source register after bypassing.
    function automatic logic [15:0] operand(input logic uses, input logic [2:0] r,
                                            input logic [15:0] d, input stim_t s);
        if (!uses)                       return d;
        if (s.mem_en && s.mem_reg == r)  return s.mem_data;
        if (s.wb_en && s.wb_reg == r)    return s.wb_data;
        return d;
    endfunction

    function automatic logic load_use(input stim_t s);
        logic dep;
        dep = (s.uses_rs && s.rs == m_ins.wr_reg) || (s.uses_rt && s.rt == m_ins.wr_reg);
        return m_ins.valid && m_ins.is_load && m_ins.wr_en && s.valid && dep;
    endfunction

    task automatic apply(input stim_t s);
        exp_t  e;
        logic  hz;
        @(negedge clk);
        rst = s.rst;
        id_valid = s.valid; id_rs_data = s.rs_data; id_rt_data = s.rt_data;
        id_imm = s.imm; id_use_imm = s.use_imm; id_rs = s.rs; id_rt = s.rt;
        id_uses_rs = s.uses_rs; id_uses_rt = s.uses_rt; id_op = s.op;
        id_inva = s.inva; id_invb = s.invb; id_cin = s.cin; id_sign = s.sign;
        id_wr_en = s.wr_en; id_wr_reg = s.wr_reg; id_is_load = s.is_load;
        stall = s.stall; flush = s.flush;
        mem_fwd_en = s.mem_en; mem_fwd_reg = s.mem_reg; mem_fwd_data = s.mem_data;
        wb_fwd_en = s.wb_en; wb_fwd_reg = s.wb_reg; wb_fwd_data = s.wb_data;
        if (!s.rst) begin
            m_ins  = '0;
            m_pend = 1'b0;
        end
        hz = load_use(s);
        e.hazard     = hz;
        e.ex_valid   = m_ins.valid;
        e.ex_wr_en   = m_ins.wr_en;
        e.ex_is_load = m_ins.is_load;
        e.ex_wr_reg  = m_ins.wr_reg;
        e.ex_st_data = operand(m_ins.uses_rt, m_ins.rt, m_ins.rt_data, s);
        e.alu_a      = operand(m_ins.uses_rs, m_ins.rs, m_ins.rs_data, s);
        e.alu_b      = m_ins.use_imm ? m_ins.imm : e.ex_st_data;
        e.alu_op     = m_ins.op;
        e.alu_inva   = m_ins.inva;
        e.alu_invb   = m_ins.invb;
        e.alu_cin    = m_ins.cin;
        e.alu_sign   = m_ins.sign;
        sb_q.push_back(e);
        @(posedge clk);
        if (s.rst) begin
            if (s.stall) begin
                m_pend = m_pend | s.flush;
            end else if (s.flush || m_pend || hz) begin
                m_ins  = '0;
                m_pend = 1'b0;
            end else begin
                m_ins = s;
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got 0x%04h expected 0x%04h", name, cyc, got, want);
        end
    endtask

    // Monitor: samples mid-low-phase, after stimulus for the cycle is settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("hazard",     {15'd0, hazard},     {15'd0, e.hazard});
                chk("ex_valid",   {15'd0, ex_valid},   {15'd0, e.ex_valid});
                chk("ex_wr_en",   {15'd0, ex_wr_en},   {15'd0, e.ex_wr_en});
                chk("ex_is_load", {15'd0, ex_is_load}, {15'd0, e.ex_is_load});
                chk("ex_wr_reg",  {13'd0, ex_wr_reg},  {13'd0, e.ex_wr_reg});
                chk("ex_st_data", ex_st_data,          e.ex_st_data);
                chk("alu_a",      alu_a,               e.alu_a);
                chk("alu_b",      alu_b,               e.alu_b);
                chk("alu_op",     {13'd0, alu_op},     {13'd0, e.alu_op});
                chk("alu_ctl",    {12'd0, alu_inva, alu_invb, alu_cin, alu_sign},
                                  {12'd0, e.alu_inva, e.alu_invb, e.alu_cin, e.alu_sign});
            end
        end
    end

    function automatic stim_t rand_stim();
        stim_t s = idle();
        s.rst     = ($urandom_range(0, 99) != 0);
        s.valid   = ($urandom_range(0, 3) != 0);
        s.rs_data = 16'($urandom);
        s.rt_data = 16'($urandom);
        s.imm     = 16'($urandom);
        s.use_imm = 1'($urandom);
        s.rs      = 3'($urandom_range(0, 3));
        s.rt      = 3'($urandom_range(0, 3));
        s.uses_rs = ($urandom_range(0, 3) != 0);
        s.uses_rt = ($urandom_range(0, 3) != 0);
        s.op      = 3'($urandom);
        {s.inva, s.invb, s.cin, s.sign} = 4'($urandom);
        s.wr_en   = 1'($urandom);
        s.wr_reg  = 3'($urandom_range(0, 3));
        s.is_load = ($urandom_range(0, 2) == 0);
        s.stall   = ($urandom_range(0, 4) == 0);
        s.flush   = ($urandom_range(0, 6) == 0);
        s.mem_en  = 1'($urandom);
        s.mem_reg = 3'($urandom_range(0, 3));
        s.mem_data = 16'($urandom);
        s.wb_en   = 1'($urandom);
        s.wb_reg  = 3'($urandom_range(0, 3));
        s.wb_data = 16'($urandom);
        return s;
    endfunction

    initial begin
        stim_t s;
        m_ins  = '0;
        m_pend = 1'b0;
        #1 rst = 1'b0;

        s = idle(); s.rst = 1'b0;
        apply(s); apply(s);
        for (int i = 0; i < 6; i++) apply(rand_stim());
        s = idle(); s.rst = 1'b0; s.valid = 1'b1; s.wr_en = 1'b1;
        apply(s);

        // Basic capture after reset release
        s = idle(); s.valid = 1'b1; s.rs_data = 16'h1234; s.rt_data = 16'h0003;
        s.rs = 3'd1; s.rt = 3'd2; s.uses_rs = 1'b1; s.uses_rt = 1'b1; s.op = 3'b100;
        apply(s);
        apply(idle());

        // rs=r2 with both bypasses hitting, then only MEM/WB while stalled
        s = idle(); s.valid = 1'b1; s.rs = 3'd2; s.uses_rs = 1'b1; s.rs_data = 16'h0101;
        apply(s);
        s = idle(); s.stall = 1'b1;
        s.mem_en = 1'b1; s.mem_reg = 3'd2; s.mem_data = 16'hAAAA;
        s.wb_en = 1'b1; s.wb_reg = 3'd2; s.wb_data = 16'h5555;
        apply(s);
        s.mem_en = 1'b0;
        apply(s);

        // Load to r3, dependent consumer of rt=r3
        s = idle(); s.valid = 1'b1; s.wr_en = 1'b1; s.is_load = 1'b1; s.wr_reg = 3'd3;
        apply(s);
        s = idle(); s.valid = 1'b1; s.rt = 3'd3; s.uses_rt = 1'b1; s.rt_data = 16'h0BAD;
        apply(s);
        apply(s);
        s = idle(); s.wb_en = 1'b1; s.wb_reg = 3'd3; s.wb_data = 16'h7777;
        apply(s);

        // Immediate B operand with forwarded store data
        s = idle(); s.valid = 1'b1; s.use_imm = 1'b1; s.imm = 16'hFFF0;
        s.rt = 3'd5; s.uses_rt = 1'b1; s.rt_data = 16'h1111;
        apply(s);
        s = idle(); s.mem_en = 1'b1; s.mem_reg = 3'd5; s.mem_data = 16'h0042;
        apply(s);

        // Stall with flush for two cycles, then deferred bubble, then normal load
        s = idle(); s.valid = 1'b1; s.rs = 3'd4; s.uses_rs = 1'b1; s.rs_data = 16'hC0DE;
        s.stall = 1'b1; s.flush = 1'b1;
        apply(s); apply(s);
        s.stall = 1'b0; s.flush = 1'b0;
        apply(s); apply(s); apply(idle());

        // Flush together with a load-use hazard gives a single bubble
        s = idle(); s.valid = 1'b1; s.wr_en = 1'b1; s.is_load = 1'b1; s.wr_reg = 3'd0;
        apply(s);
        s = idle(); s.valid = 1'b1; s.rs = 3'd0; s.uses_rs = 1'b1; s.flush = 1'b1;
        apply(s);
        s.flush = 1'b0;
        apply(s); apply(idle());

        for (int i = 0; i < 3000; i++) apply(rand_stim());

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #5;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
